peripheral_mpi_ahb2bus: RTL and testbench
=========================================

Name: peripheral_mpi_ahb2bus

Overview:
AHB-Lite slave front end that converts pipelined AHB address/data phases into the generic MPI bus handshake (bus_addr/bus_we/bus_en/bus_data_in/bus_data_out/bus_ack/bus_err). It sits directly upstream of peripheral_mpi_buffer and drives its bus-side ports. The block adds wait-state insertion, the two-cycle AHB error response, alignment/size checking and a no-ack watchdog.

Parameters:
PLEN, 32, AHB address width; bus_addr carries PLEN bits.
XLEN, 32, AHB data width; generic bus data width.
TIMEOUT, 255, cycles in ACCESS without bus_ack/bus_err before a forced error; 0 disables; legal range 0..65535.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
ahb_hsel_i  in  1  slave select.
ahb_haddr_i  in  PLEN  address-phase address.
ahb_hwdata_i  in  XLEN  data-phase write data.
ahb_hwrite_i  in  1  1 = write.
ahb_hsize_i  in  3  transfer size.
ahb_htrans_i  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
ahb_hready_i  in  1  bus-wide HREADY; qualifies the address phase.
ahb_hrdata_o  out  XLEN  read data.
ahb_hreadyout_o  out  1  slave ready.
ahb_hresp_o  out  1  0 = OKAY, 1 = ERROR.
bus_addr  out  PLEN  latched address.
bus_we  out  1  latched write flag.
bus_en  out  1  access request.
bus_data_in  out  XLEN  write data to the buffer.
bus_data_out  in  XLEN  read data from the buffer.
bus_ack  in  1  single-cycle completion.
bus_err  in  1  single-cycle error completion.

Behaviour:
- States: IDLE, ACCESS, ERR1, ERR2. Reset or rst=1 in any state (including mid-transfer) gives IDLE and timeout count = 0.
- Reset values: hreadyout=1, hresp=0, hrdata=0, bus_en=0, bus_we=0, bus_addr=0, bus_data_in=0.
- Accept condition: hsel & hready_i & htrans[1]. On accept, register haddr, hwrite, hsize.
- Legal access: hsize=2 and haddr[1:0]=0. An accepted legal access moves to ACCESS. An accepted illegal access moves to ERR1 and never asserts bus_en.
- IDLE: hreadyout=1, hresp=0, bus_en=0. IDLE/BUSY transfers complete with zero wait states and OKAY.
- ACCESS outputs: bus_en=1; bus_addr/bus_we come from the registered values; bus_data_in=ahb_hwdata_i (combinational, held by the master through wait states); hreadyout=bus_ack & ~bus_err; hresp=0; hrdata=bus_data_out in the ack cycle, otherwise 0.
- ACCESS transitions:
  - bus_err=1 goes to ERR1. err has priority over a simultaneous ack.
  - bus_ack=1 with an accept in the same cycle stays in ACCESS with the new registered values. This is a back-to-back transfer: bus_en stays high and bus_addr changes on the next cycle.
  - bus_ack=1 without an accept goes to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack/err (TIMEOUT≠0), the next state is ERR1.
  - The counter clears on every ACCESS entry.
- ERR1: hresp=1, hreadyout=0, bus_en=0. Always goes to ERR2.
- ERR2: hresp=1, hreadyout=1, bus_en=0. Goes to ACCESS or ERR1 on accept (per the legality check), else IDLE.
- Latency: one cycle from address phase to bus_en. Zero wait states when the buffer acks in the first ACCESS cycle. Error response is always exactly 2 cycles.
- bus_ack/bus_err outside ACCESS are ignored.

Test Plan:
1. Write haddr=0x10, hwdata=0xDEADBEEF, buffer acks in the first ACCESS cycle -> bus_en=1 for 1 cycle with bus_addr=0x10, bus_we=1, bus_data_in=0xDEADBEEF; hreadyout=1 in that cycle; hresp=0.
2. Read haddr=0x4, buffer acks after 3 cycles with bus_data_out=0x12345678 -> hreadyout=0,0,0,1; hrdata=0x12345678 in the ack cycle; then IDLE.
3. Back-to-back NONSEQ writes to 0x0 and 0x4, each acked immediately -> bus_en high for 2 consecutive cycles, bus_addr 0x0 then 0x4, no bubble.
4. Read with haddr=0x2 (misaligned) and separately hsize=0 -> bus_en stays 0; {hreadyout,hresp}=(0,1) then (1,1).
5. bus_err and bus_ack asserted together in ACCESS; separately TIMEOUT=4 with no ack -> ERR1/ERR2 response; in the timeout case ERR1 is entered after exactly 4 ACCESS cycles.
6. rst asserted in ACCESS while the buffer stalls -> the next cycle is IDLE with bus_en=0, hreadyout=1, hresp=0, hrdata=0.

Source files
------------

// File: rtl/peripheral_mpi_ahb2bus.sv
// AHB-Lite slave front end driving the generic MPI bus handshake.
// Adds wait states, a two-cycle ERROR response, size/alignment checks and a no-ack watchdog.
module peripheral_mpi_ahb2bus #(
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ahb_hsel_i,
  input  logic [PLEN-1:0] ahb_haddr_i,
  input  logic [XLEN-1:0] ahb_hwdata_i,
  input  logic            ahb_hwrite_i,
  input  logic [2:0]      ahb_hsize_i,
  input  logic [1:0]      ahb_htrans_i,
  input  logic            ahb_hready_i,
  output logic [XLEN-1:0] ahb_hrdata_o,
  output logic            ahb_hreadyout_o,
  output logic            ahb_hresp_o,
  output logic [PLEN-1:0] bus_addr,
  output logic            bus_we,
  output logic            bus_en,
  output logic [XLEN-1:0] bus_data_in,
  input  logic [XLEN-1:0] bus_data_out,
  input  logic            bus_ack,
  input  logic            bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [15:0]     cnt_p0, cnt_nxt;
  logic [PLEN-1:0] addr_p0;
  logic            we_p0;
  logic [2:0]      size_p0;
  logic            accept, legal, take;
  logic            unused_ok;

  function automatic logic is_legal(input logic [2:0] sz, input logic [1:0] lsb);
    return (sz == 3'd2) && (lsb == 2'b00);
  endfunction

  assign accept = ahb_hsel_i & ahb_hready_i & ahb_htrans_i[1];
  assign legal  = is_legal(ahb_hsize_i, ahb_haddr_i[1:0]);
  // A new address phase is only taken where this slave is completing (or idle).
  assign take   = accept & ((state == IDLE) | (state == ERR2) |
                            ((state == ACCESS) & bus_ack & ~bus_err));

  assign unused_ok = ^{ahb_htrans_i[0], size_p0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt_p0 <= 16'd0;
    end else begin
      state  <= state_nxt;
      cnt_p0 <= cnt_nxt;
    end
  end

  // Address-phase capture stage
  always_ff @(posedge clk) begin
    if (take) begin
      addr_p0 <= ahb_haddr_i;
      we_p0   <= ahb_hwrite_i;
      size_p0 <= ahb_hsize_i;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = 16'd0;
    case (state)
      IDLE: begin
        if (take) state_nxt = legal ? ACCESS : ERR1;
      end
      ACCESS: begin
        if (bus_err) begin
          state_nxt = ERR1;
        end else if (bus_ack) begin
          if (take) state_nxt = legal ? ACCESS : ERR1;
          else      state_nxt = IDLE;
        end else if (TO_EN && (cnt_p0 == TO_LAST)) begin
          state_nxt = ERR1;
        end else begin
          state_nxt = ACCESS;
          cnt_nxt   = cnt_p0 + 16'd1;
        end
      end
      ERR1: state_nxt = ERR2;
      ERR2: begin
        if (take) state_nxt = legal ? ACCESS : ERR1;
        else      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ahb_hreadyout_o = 1'b1;
    ahb_hresp_o     = 1'b0;
    ahb_hrdata_o    = '0;
    bus_en          = 1'b0;
    bus_we          = 1'b0;
    bus_addr        = '0;
    bus_data_in     = '0;
    case (state)
      ACCESS: begin
        bus_en          = 1'b1;
        bus_we          = we_p0;
        bus_addr        = addr_p0;
        bus_data_in     = ahb_hwdata_i;
        ahb_hreadyout_o = bus_ack & ~bus_err;
        ahb_hrdata_o    = bus_ack ? bus_data_out : '0;
      end
      ERR1: begin
        ahb_hreadyout_o = 1'b0;
        ahb_hresp_o     = 1'b1;
      end
      ERR2: ahb_hresp_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_peripheral_mpi_ahb2bus.sv
// Bench for peripheral_mpi_ahb2bus: directed scenarios plus randomized transfers
// checked against a transfer-level outcome model.
module tb_peripheral_mpi_ahb2bus;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr, hwdata, hrdata, bus_addr, bus_data_in, bus_data_out;
  logic        hwrite, hready, hreadyout, hresp, bus_we, bus_en, bus_ack, bus_err;
  logic [2:0]  hsize;
  logic [1:0]  htrans;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  peripheral_mpi_ahb2bus #(.PLEN(32), .XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ahb_hsel_i(hsel), .ahb_haddr_i(haddr), .ahb_hwdata_i(hwdata),
    .ahb_hwrite_i(hwrite), .ahb_hsize_i(hsize), .ahb_htrans_i(htrans),
    .ahb_hready_i(hready), .ahb_hrdata_o(hrdata), .ahb_hreadyout_o(hreadyout),
    .ahb_hresp_o(hresp), .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hsel = 0; htrans = 2'd0; haddr = 0; hwrite = 0; hsize = 3'd2;
    bus_ack = 0; bus_err = 0;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    checks++;
    if ({bus_en, hreadyout, hresp, hrdata, bus_addr, bus_we, bus_data_in} !== {3'b010, 32'd0, 32'd0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL %s idle: en=%b rdy=%b resp=%b rdata=%h addr=%h we=%b din=%h, required en=0 rdy=1 resp=0 rest 0",
               tag, bus_en, hreadyout, hresp, hrdata, bus_addr, bus_we, bus_data_in);
    end
  endtask

  // One transfer from address phase to the return to idle. ack_dly/err_dly give the
  // 0-based ACCESS cycle in which the buffer responds (-1 = never).
  task automatic run_xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_dly, input int err_dly, input string tag);
    bit legal, ok_end;
    int c;
    legal  = (sz == 3'd2) && (a % 4 == 0);
    ok_end = 0;
    hsel = 1; htrans = 2'd2; haddr = a; hwrite = wr; hsize = sz;
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
      errors++;
      $display("FAIL %s addr_phase: rdy=%b resp=%b, required 1 0", tag, hreadyout, hresp);
    end
    step();
    hsel = 0; htrans = 2'd0; hwdata = wd; bus_data_out = rd;
    if (legal) begin
      c = 0;
      while (1) begin
        bus_ack = (c == ack_dly);
        bus_err = (c == err_dly);
        @(negedge clk);
        checks++;
        if (bus_en !== 1'b1 || bus_addr !== a || bus_we !== wr || bus_data_in !== wd || hresp !== 1'b0) begin
          errors++;
          $display("FAIL %s access c=%0d: en=%b addr=%h we=%b din=%h resp=%b, required 1 %h %b %h 0",
                   tag, c, bus_en, bus_addr, bus_we, bus_data_in, hresp, a, wr, wd);
        end
        checks++;
        if (hreadyout !== (c == ack_dly && c != err_dly)) begin
          errors++;
          $display("FAIL %s ready c=%0d: got %b required %b", tag, c, hreadyout, (c == ack_dly && c != err_dly));
        end
        if (c != err_dly) begin
          checks++;
          if (hrdata !== ((c == ack_dly) ? rd : 32'd0)) begin
            errors++;
            $display("FAIL %s rdata c=%0d: got %h required %h", tag, c, hrdata, (c == ack_dly) ? rd : 32'd0);
          end
        end
        step();
        bus_ack = 0; bus_err = 0;
        if (c == err_dly) break;
        if (c == ack_dly) begin ok_end = 1; break; end
        if (c == TO - 1) break;
        c++;
      end
    end
    if (!ok_end) begin
      @(negedge clk);
      checks++;
      if ({bus_en, hreadyout, hresp} !== 3'b001) begin
        errors++;
        $display("FAIL %s err1: en=%b rdy=%b resp=%b, required 0 0 1", tag, bus_en, hreadyout, hresp);
      end
      step();
      @(negedge clk);
      checks++;
      if ({bus_en, hreadyout, hresp} !== 3'b011) begin
        errors++;
        $display("FAIL %s err2: en=%b rdy=%b resp=%b, required 0 1 1", tag, bus_en, hreadyout, hresp);
      end
      step();
    end
    expect_idle(tag);
    step();
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); hwdata = 32'hA5A5A5A5; bus_data_out = 32'h5A5A5A5A;
    step(); step();
    expect_idle("reset");
    step();
    rst = 0;
    step();
  endtask

  task automatic test_write_zero_wait();
    run_xfer(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 0, -1, "write0");
  endtask

  task automatic test_read_wait();
    run_xfer(32'h4, 1'b0, 3'd2, 32'h0, 32'h12345678, 3, -1, "read3");
  endtask

  task automatic test_back_to_back();
    hsel = 1; htrans = 2'd2; haddr = 32'h0; hwrite = 1; hsize = 3'd2;
    step();
    hwdata = 32'h11111111; bus_ack = 1; haddr = 32'h4;
    @(negedge clk);
    checks++;
    if ({bus_en, hreadyout} !== 2'b11 || bus_addr !== 32'h0 || bus_data_in !== 32'h11111111) begin
      errors++;
      $display("FAIL b2b first: en=%b rdy=%b addr=%h din=%h, required 1 1 0 11111111", bus_en, hreadyout, bus_addr, bus_data_in);
    end
    step();
    hsel = 0; htrans = 2'd0; hwdata = 32'h22222222;
    @(negedge clk);
    checks++;
    if ({bus_en, hreadyout, bus_we} !== 3'b111 || bus_addr !== 32'h4 || bus_data_in !== 32'h22222222) begin
      errors++;
      $display("FAIL b2b second: en=%b rdy=%b we=%b addr=%h din=%h, required 1 1 1 4 22222222",
               bus_en, hreadyout, bus_we, bus_addr, bus_data_in);
    end
    step();
    bus_ack = 0;
    expect_idle("b2b_end");
    step();
  endtask

  task automatic test_illegal();
    run_xfer(32'h2, 1'b0, 3'd2, 32'h0, 32'hCAFE0000, 0, -1, "misalign");
    run_xfer(32'h8, 1'b0, 3'd0, 32'h0, 32'hCAFE0001, 0, -1, "byte");
  endtask

  task automatic test_err_ack();
    run_xfer(32'h20, 1'b1, 3'd2, 32'h01020304, 32'h0, 1, 1, "err_ack");
  endtask

  task automatic test_timeout();
    run_xfer(32'h24, 1'b0, 3'd2, 32'h0, 32'h0BADF00D, -1, -1, "timeout");
  endtask

  task automatic test_ignore_idle_resp();
    bus_ack = 1; bus_err = 1;
    expect_idle("idle_ack_err");
    step();
    bus_ack = 0; bus_err = 0;
  endtask

  task automatic test_rst_mid();
    hsel = 1; htrans = 2'd2; haddr = 32'h30; hwrite = 0; hsize = 3'd2;
    step();
    hsel = 0; htrans = 2'd0; bus_data_out = 32'hFEEDFACE;
    step(); step();
    rst = 1;
    step();
    rst = 0;
    expect_idle("rst_mid");
    step();
    // A fresh transfer after the reset must see the full watchdog window again.
    run_xfer(32'h34, 1'b0, 3'd2, 32'h0, 32'h0, -1, -1, "post_rst_timeout");
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd;
    logic [2:0]  sz;
    int ad, ed;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom_range(0, 255) * 4;
      if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
      sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      wd = $urandom;
      rd = $urandom;
      ad = $urandom_range(0, 5);
      ed = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_xfer(a, 1'($urandom_range(0, 1)), sz, wd, rd, ad, ed, "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_back_to_back();
    test_illegal();
    test_err_ack();
    test_timeout();
    test_ignore_idle_resp();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
